// File: rtl/packet_vomiter_axil_pkg.sv
// Shared constants for the packet_vomiter AXI-Lite master: FSM encoding,
// AXI response codes, timeout counter width and the register-template offset map.
package packet_vomiter_axil_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_WRESP = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_RDATA = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TMO_CNT_W = 16;

    // Register template map shared with sequencers and benches
    localparam logic [31:0] REG_ID      = 32'h0000_0000;
    localparam logic [31:0] REG_VERSION = 32'h0000_0004;
    localparam logic [31:0] REG_RESET   = 32'h0000_0008;
    localparam logic [31:0] REG_ENABLE  = 32'h0000_000C;
    localparam logic [31:0] REG_DEBUG   = 32'h0000_0010;
    localparam logic [31:0] REG_PKTIN   = 32'h0000_0014;
    localparam logic [31:0] REG_PKTOUT  = 32'h0000_0018;

    function automatic logic is_timed_state(input logic [2:0] st);
        return (st == ST_WRITE) || (st == ST_WRESP) || (st == ST_READ) || (st == ST_RDATA);
    endfunction

endpackage

// File: rtl/packet_vomiter_axil_if.sv
// AXI4-Lite bus between the packet_vomiter master and a register slave.
// Handshake: a beat transfers on a rising clk edge where VALID and READY are both high;
// VALID, once raised, stays high with stable payload until that edge.
interface packet_vomiter_axil_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   M_AXI_AWADDR;
    logic                M_AXI_AWVALID;
    logic                M_AXI_AWREADY;
    logic [DATA_W-1:0]   M_AXI_WDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic                M_AXI_WVALID;
    logic                M_AXI_WREADY;
    logic [1:0]          M_AXI_BRESP;
    logic                M_AXI_BVALID;
    logic                M_AXI_BREADY;
    logic [ADDR_W-1:0]   M_AXI_ARADDR;
    logic                M_AXI_ARVALID;
    logic                M_AXI_ARREADY;
    logic [DATA_W-1:0]   M_AXI_RDATA;
    logic [1:0]          M_AXI_RRESP;
    logic                M_AXI_RVALID;
    logic                M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
               M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
               M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
               M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
    );
endinterface

// File: rtl/packet_vomiter_axil_timer.sv
// Per-state handshake watchdog: clears on state change, counts while run is high,
// flags expiry on the LIMIT-th cycle spent in one state.
module packet_vomiter_axil_timer
    import packet_vomiter_axil_pkg::*;
#(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam logic [TMO_CNT_W-1:0] LAST = TMO_CNT_W'(LIMIT - 1);

    logic [TMO_CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired = run && (count_q == LAST);

endmodule

// File: rtl/packet_vomiter_axil_master.sv
// Single-outstanding AXI4-Lite master turning register commands into bus transactions.
// Define PACKET_VOMITER_AXIL_TIMEOUT_EN to abort stalled handshakes after C_TIMEOUT_CYCLES.
module packet_vomiter_axil_master
    import packet_vomiter_axil_pkg::*;
#(
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h0000_0000,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_rnw,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            rsp_timeout,
    output logic                            busy,
    output logic [2:0]                      dbg_state,
    packet_vomiter_axil_if.master           m_axi
);
    logic [2:0] state_q, state_d;
    logic       awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic       rsp_valid_q, timeout_q, busy_q;
    logic [1:0] resp_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, rdata_q;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   issue_addr;
    logic       aw_fin, w_fin, tmo_expired;

    assign issue_addr = cmd_addr | C_BASE_ADDRESS[C_M_AXI_ADDR_WIDTH-1:0];

    // A write channel is finished once its VALID has dropped or it handshakes this edge
    assign aw_fin = !awvalid_q || m_axi.M_AXI_AWREADY;
    assign w_fin  = !wvalid_q  || m_axi.M_AXI_WREADY;

`ifdef PACKET_VOMITER_AXIL_TIMEOUT_EN
    packet_vomiter_axil_timer #(
        .LIMIT (C_TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .run     (is_timed_state(state_q)),
        .expired (tmo_expired)
    );
`else
    localparam int unused_timeout_cycles = C_TIMEOUT_CYCLES;
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (cmd_valid) state_d = cmd_rnw ? ST_READ : ST_WRITE;
            ST_WRITE: if (aw_fin && w_fin) state_d = ST_WRESP;
            ST_WRESP: if (m_axi.M_AXI_BVALID && bready_q) state_d = ST_RESP;
            ST_READ:  if (arvalid_q && m_axi.M_AXI_ARREADY) state_d = ST_RDATA;
            ST_RDATA: if (m_axi.M_AXI_RVALID && rready_q) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (tmo_expired) state_d = ST_RESP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (tmo_expired) begin
                // Abandon every channel; late slave handshakes fall on a master that is no longer listening
                awvalid_q   <= 1'b0;
                wvalid_q    <= 1'b0;
                bready_q    <= 1'b0;
                arvalid_q   <= 1'b0;
                rready_q    <= 1'b0;
                rsp_valid_q <= 1'b1;
                resp_q      <= RESP_SLVERR;
                rdata_q     <= '0;
                timeout_q   <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: if (cmd_valid) begin
                        busy_q    <= 1'b1;
                        timeout_q <= 1'b0;
                        if (cmd_rnw) begin
                            arvalid_q <= 1'b1;
                            araddr_q  <= issue_addr;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= issue_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                        end
                    end
                    ST_WRITE: begin
                        if (m_axi.M_AXI_AWREADY) awvalid_q <= 1'b0;
                        if (m_axi.M_AXI_WREADY)  wvalid_q  <= 1'b0;
                        if (aw_fin && w_fin)     bready_q  <= 1'b1;
                    end
                    ST_WRESP: if (m_axi.M_AXI_BVALID && bready_q) begin
                        bready_q    <= 1'b0;
                        resp_q      <= m_axi.M_AXI_BRESP;
                        rdata_q     <= '0;
                        rsp_valid_q <= 1'b1;
                    end
                    ST_READ: if (m_axi.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                    ST_RDATA: if (m_axi.M_AXI_RVALID && rready_q) begin
                        rready_q    <= 1'b0;
                        resp_q      <= m_axi.M_AXI_RRESP;
                        rdata_q     <= m_axi.M_AXI_RDATA;
                        rsp_valid_q <= 1'b1;
                    end
                    ST_RESP: if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_resp    = resp_q;
    assign rsp_timeout = timeout_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

    assign m_axi.M_AXI_AWADDR  = awaddr_q;
    assign m_axi.M_AXI_AWVALID = awvalid_q;
    assign m_axi.M_AXI_WDATA   = wdata_q;
    assign m_axi.M_AXI_WSTRB   = wstrb_q;
    assign m_axi.M_AXI_WVALID  = wvalid_q;
    assign m_axi.M_AXI_BREADY  = bready_q;
    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_packet_vomiter_axil_master.sv
// Directed bench for packet_vomiter_axil_master against a small reactive register slave.
// Define PACKET_VOMITER_AXIL_TIMEOUT_EN for both bench and RTL to include the timeout scenario.
module tb_packet_vomiter_axil_master;
    import packet_vomiter_axil_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad = 0;

    packet_vomiter_axil_if bus ();

    packet_vomiter_axil_master #(
        .C_BASE_ADDRESS   (BASE),
        .C_TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk (clk), .reset (reset),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_rnw (cmd_rnw),
        .cmd_addr (cmd_addr), .cmd_wdata (cmd_wdata), .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_rdata (rsp_rdata),
        .rsp_resp (rsp_resp), .rsp_timeout (rsp_timeout), .busy (busy),
        .dbg_state (dbg_state), .m_axi (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reactive register slave ----------------
    logic [31:0] mem [0:7];
    int          cyc = 0;
    int          aw_wait = 0, w_wait = 0, aw_cyc = 0, w_cyc = 0;
    logic        ar_block = 1'b0;
    logic        got_aw = 0, got_w = 0, bdone = 0, rd_pend = 0, rdone = 0;
    logic        bready_early = 0;
    int          aw_hs_cyc = 0, w_hs_cyc = 0, arvalid_cnt = 0;
    logic [31:0] last_awaddr = '0, last_araddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem[0] = 32'h0000_DA01;
        mem[1] = 32'h0001_0203;
        bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0; bus.M_AXI_BRESP = 0;
        bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; bus.M_AXI_RDATA = 0; bus.M_AXI_RRESP = 0;
    end

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            got_aw = 0; got_w = 0; bdone = 0; rd_pend = 0; rdone = 0;
        end else begin
            if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
                got_aw = 1; aw_hs_cyc = cyc; last_awaddr = bus.M_AXI_AWADDR;
            end
            if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
                got_w = 1; w_hs_cyc = cyc; last_wdata = bus.M_AXI_WDATA; last_wstrb = bus.M_AXI_WSTRB;
            end
            if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) bdone = 1;
            if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
                rd_pend = 1; last_araddr = bus.M_AXI_ARADDR;
            end
            if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) rdone = 1;
            if (bus.M_AXI_BREADY && (bus.M_AXI_AWVALID || bus.M_AXI_WVALID)) bready_early = 1;
            if (bus.M_AXI_ARVALID) arvalid_cnt++;
        end
        #1;
        if (reset) begin
            bus.M_AXI_AWREADY = 0; bus.M_AXI_WREADY = 0; bus.M_AXI_BVALID = 0;
            bus.M_AXI_ARREADY = 0; bus.M_AXI_RVALID = 0; aw_cyc = 0; w_cyc = 0;
        end else begin
            if (bus.M_AXI_AWVALID) begin bus.M_AXI_AWREADY = (aw_cyc >= aw_wait); aw_cyc++; end
            else begin bus.M_AXI_AWREADY = 0; aw_cyc = 0; end
            if (bus.M_AXI_WVALID) begin bus.M_AXI_WREADY = (w_cyc >= w_wait); w_cyc++; end
            else begin bus.M_AXI_WREADY = 0; w_cyc = 0; end
            bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && !ar_block;
            if (bdone) begin bus.M_AXI_BVALID = 0; bdone = 0; end
            if (got_aw && got_w) begin
                for (int b = 0; b < 4; b++)
                    if (last_wstrb[b]) mem[last_awaddr[4:2]][8*b +: 8] = last_wdata[8*b +: 8];
                bus.M_AXI_BVALID = 1; bus.M_AXI_BRESP = RESP_OKAY;
                got_aw = 0; got_w = 0;
            end
            if (rdone) begin bus.M_AXI_RVALID = 0; rdone = 0; end
            if (rd_pend) begin
                bus.M_AXI_RVALID = 1; bus.M_AXI_RDATA = mem[last_araddr[4:2]]; bus.M_AXI_RRESP = RESP_OKAY;
                rd_pend = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
        int n;
        @(negedge clk);
        cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws; cmd_valid = 1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL issue_accept cmd_ready=%b after %0d cycles, need 1", cmd_ready, n); end
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic take_rsp(output logic [31:0] rd, output logic [1:0] rr, output logic to, output int lat);
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; rr = rsp_resp; to = rsp_timeout;
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rsp_wait rsp_valid=%b after %0d cycles, need 1", rsp_valid, lat); end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rsp_release cmd_ready=%b busy=%b rsp_valid=%b, need 1 0 0", cmd_ready, busy, rsp_valid);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b need 1", cmd_ready); end
        total++;
        if ({rsp_valid, busy, rsp_timeout, rsp_resp} !== 5'b0) begin
            bad++; $display("FAIL reset_rsp got v=%b busy=%b to=%b resp=%b need zeros", rsp_valid, busy, rsp_timeout, rsp_resp);
        end
        total++;
        if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got %h need 0", rsp_rdata); end
        total++;
        if ({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY} !== 5'b0) begin
            bad++; $display("FAIL reset_handshakes got %b need 00000",
                {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY});
        end
        total++;
        if ({bus.M_AXI_AWADDR, bus.M_AXI_ARADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB} !== 100'h0) begin
            bad++; $display("FAIL reset_payload got aw=%h ar=%h wd=%h ws=%h need zeros",
                bus.M_AXI_AWADDR, bus.M_AXI_ARADDR, bus.M_AXI_WDATA, bus.M_AXI_WSTRB);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL reset_state got %0d need %0d", dbg_state, ST_IDLE); end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_read_id();
        logic [31:0] rd; logic [1:0] rr; logic to; int lat;
        issue(1'b1, REG_ID, 32'h0, 4'h0);
        total++;
        if (bus.M_AXI_ARVALID !== 1'b1 || bus.M_AXI_ARADDR !== 32'h4000_0000) begin
            bad++; $display("FAIL read_id_ar arvalid=%b araddr=%h need 1 40000000", bus.M_AXI_ARVALID, bus.M_AXI_ARADDR);
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL read_id_busy got %b need 1", busy); end
        take_rsp(rd, rr, to, lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL read_id_latency got %0d need 3", lat); end
        total++;
        if (rd !== 32'h0000_DA01) begin bad++; $display("FAIL read_id_rdata got %h need 0000da01", rd); end
        total++;
        if (rr !== 2'b00 || to !== 1'b0) begin bad++; $display("FAIL read_id_resp got resp=%b to=%b need 00 0", rr, to); end
    endtask

    task automatic test_write_enable();
        logic [31:0] rd; logic [1:0] rr; logic to; int lat;
        aw_wait = 2; w_wait = 0; bready_early = 0;
        issue(1'b0, REG_ENABLE, 32'h1, 4'hF);
        take_rsp(rd, rr, to, lat);
        aw_wait = 0;
        total++;
        if (aw_hs_cyc - w_hs_cyc !== 2) begin bad++; $display("FAIL wr_order aw-w cycles got %0d need 2", aw_hs_cyc - w_hs_cyc); end
        total++;
        if (bready_early !== 1'b0) begin bad++; $display("FAIL wr_bready_early got %b need 0", bready_early); end
        total++;
        if (lat !== 5) begin bad++; $display("FAIL wr_latency got %0d need 5", lat); end
        total++;
        if (rr !== 2'b00 || rd !== 32'h0 || to !== 1'b0) begin
            bad++; $display("FAIL wr_rsp got resp=%b rdata=%h to=%b need 00 0 0", rr, rd, to);
        end
        total++;
        if (last_awaddr !== 32'h4000_000C) begin bad++; $display("FAIL wr_awaddr got %h need 4000000c", last_awaddr); end
        issue(1'b1, REG_ENABLE, 32'h0, 4'h0);
        take_rsp(rd, rr, to, lat);
        total++;
        if (rd !== 32'h1) begin bad++; $display("FAIL enable_readback got %h need 00000001", rd); end
    endtask

    task automatic test_write_strobe();
        logic [31:0] rd; logic [1:0] rr; logic to; int lat;
        issue(1'b0, REG_DEBUG, 32'hAABB_CCDD, 4'h1);
        total++;
        if (bus.M_AXI_WSTRB !== 4'h1 || bus.M_AXI_WDATA !== 32'hAABB_CCDD) begin
            bad++; $display("FAIL strb_bus got wstrb=%h wdata=%h need 1 aabbccdd", bus.M_AXI_WSTRB, bus.M_AXI_WDATA);
        end
        take_rsp(rd, rr, to, lat);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL strb_latency got %0d need 3", lat); end
        total++;
        if (mem[4] !== 32'h0000_00DD) begin bad++; $display("FAIL strb_store got %h need 000000dd", mem[4]); end
        issue(1'b1, REG_DEBUG, 32'h0, 4'h0);
        take_rsp(rd, rr, to, lat);
        total++;
        if (rd !== 32'h0000_00DD) begin bad++; $display("FAIL strb_readback got %h need 000000dd", rd); end
    endtask

    task automatic test_rsp_hold();
        logic [31:0] rd; logic [1:0] rr; logic to; int lat;
        int n;
        issue(1'b1, REG_VERSION, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        cmd_rnw = 1'b0; cmd_addr = REG_PKTIN; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF; cmd_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0001_0203 || rsp_resp !== 2'b00) begin
                bad++; $display("FAIL hold_rsp cycle %0d got v=%b rdata=%h resp=%b need 1 00010203 00", i, rsp_valid, rsp_rdata, rsp_resp);
            end
            total++;
            if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL hold_cmd cycle %0d got cmd_ready=%b busy=%b need 0 1", i, cmd_ready, busy);
            end
            total++;
            if (bus.M_AXI_AWVALID !== 1'b0 || bus.M_AXI_ARVALID !== 1'b0 || bus.M_AXI_WVALID !== 1'b0) begin
                bad++; $display("FAIL hold_bus cycle %0d got aw=%b w=%b ar=%b need 0 0 0", i,
                    bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID);
            end
        end
        cmd_valid = 0;
        take_rsp(rd, rr, to, lat);
        total++;
        if (rd !== 32'h0001_0203) begin bad++; $display("FAIL hold_final got %h need 00010203", rd); end
        total++;
        if (mem[5] !== 32'h0) begin bad++; $display("FAIL hold_no_write got %h need 0", mem[5]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic [1:0] rr; logic to; int lat;
        int seen;
        aw_wait = 10; w_wait = 10;
        issue(1'b0, REG_PKTOUT, 32'h55, 4'hF);
        total++;
        if (bus.M_AXI_AWVALID !== 1'b1) begin bad++; $display("FAIL mid_awvalid_before got %b need 1", bus.M_AXI_AWVALID); end
        #2 reset = 1;
        #1;
        total++;
        if (bus.M_AXI_AWVALID !== 1'b0 || bus.M_AXI_WVALID !== 1'b0) begin
            bad++; $display("FAIL mid_async_clear got aw=%b w=%b need 0 0", bus.M_AXI_AWVALID, bus.M_AXI_WVALID);
        end
        total++;
        if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
            bad++; $display("FAIL mid_state got state=%0d busy=%b need 0 0", dbg_state, busy);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 0; aw_wait = 0; w_wait = 0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL mid_no_rsp got %0d valid cycles need 0", seen); end
        issue(1'b0, REG_PKTOUT, 32'h77, 4'hF);
        take_rsp(rd, rr, to, lat);
        total++;
        if (rr !== 2'b00 || lat !== 3) begin bad++; $display("FAIL mid_recover_wr got resp=%b lat=%0d need 00 3", rr, lat); end
        issue(1'b1, REG_PKTOUT, 32'h0, 4'h0);
        take_rsp(rd, rr, to, lat);
        total++;
        if (rd !== 32'h77) begin bad++; $display("FAIL mid_recover_rd got %h need 00000077", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic [1:0] rr; logic to; int lat;
        aw_wait = 0; w_wait = 1; bready_early = 0;
        issue(1'b0, REG_PKTIN, 32'h1234_5678, 4'hF);
        take_rsp(rd, rr, to, lat);
        w_wait = 0;
        total++;
        if (w_hs_cyc - aw_hs_cyc !== 1) begin bad++; $display("FAIL b2b_order w-aw cycles got %0d need 1", w_hs_cyc - aw_hs_cyc); end
        total++;
        if (lat !== 4 || bready_early !== 1'b0) begin
            bad++; $display("FAIL b2b_wr got lat=%0d bready_early=%b need 4 0", lat, bready_early);
        end
        issue(1'b1, REG_PKTIN, 32'h0, 4'h0);
        take_rsp(rd, rr, to, lat);
        total++;
        if (rd !== 32'h1234_5678 || lat !== 3) begin bad++; $display("FAIL b2b_rd got %h lat=%0d need 12345678 3", rd, lat); end
        total++;
        if (last_araddr !== 32'h4000_0014) begin bad++; $display("FAIL b2b_araddr got %h need 40000014", last_araddr); end
    endtask

`ifdef PACKET_VOMITER_AXIL_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] rd; logic [1:0] rr; logic to; int lat;
        ar_block = 1; arvalid_cnt = 0;
        issue(1'b1, REG_ID, 32'h0, 4'h0);
        take_rsp(rd, rr, to, lat);
        ar_block = 0;
        total++;
        if (arvalid_cnt !== TMO) begin bad++; $display("FAIL tmo_arvalid_cycles got %0d need %0d", arvalid_cnt, TMO); end
        total++;
        if (rr !== RESP_SLVERR || to !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL tmo_rsp got resp=%b to=%b rdata=%h need 10 1 0", rr, to, rd);
        end
        total++;
        if (lat !== TMO + 1) begin bad++; $display("FAIL tmo_latency got %0d need %0d", lat, TMO + 1); end
        issue(1'b1, REG_ID, 32'h0, 4'h0);
        take_rsp(rd, rr, to, lat);
        total++;
        if (rd !== 32'h0000_DA01 || to !== 1'b0) begin bad++; $display("FAIL tmo_recover got %h to=%b need 0000da01 0", rd, to); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_id();
        test_write_enable();
        test_write_strobe();
        test_rsp_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef PACKET_VOMITER_AXIL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
